// File: rtl/lmi_watch_pkg.sv
// rtl/lmi_watch_pkg.sv - shared encodings and record layout for the LMI watch trace
package lmi_watch_pkg;

    typedef enum logic [1:0] {
        TR_IFETCH = 2'b00,
        TR_DREAD  = 2'b01,
        TR_DWRITE = 2'b10
    } tr_type_e;

    // WP_CTRL = {en, ifetch, dread, dwrite}
    localparam int CTRL_EN     = 3;
    localparam int CTRL_IFETCH = 2;
    localparam int CTRL_DREAD  = 1;
    localparam int CTRL_DWRITE = 0;

    // Record layout, LSB first: type, byen, data, addr, wp
    localparam int REC_TYPE_LSB = 0;
    localparam int REC_BYEN_LSB = 2;
    localparam int REC_DATA_LSB = 6;

    function automatic int rec_width(input int addr_w, input int data_w, input int wp_w);
        return REC_DATA_LSB + data_w + addr_w + wp_w;
    endfunction

endpackage

// File: rtl/lmi_watch_fifo.sv
// rtl/lmi_watch_fifo.sv - trace record FIFO with two write ports and one read port
module lmi_watch_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int LVL_W = PTR_W + 1
) (
    input  logic             CLK,
    input  logic             RESET_D1_R_N,
    input  logic             push0,
    input  logic [WIDTH-1:0] wdata0,
    input  logic             push1,
    input  logic [WIDTH-1:0] wdata1,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic [LVL_W-1:0] level
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr1_ptr;

    // Second write lands behind the first when both are issued together
    assign wr1_ptr = wr_ptr + PTR_W'(push0);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge CLK or negedge RESET_D1_R_N) begin
        if (!RESET_D1_R_N) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            wr_ptr <= wr_ptr + PTR_W'(push0) + PTR_W'(push1);
            rd_ptr <= rd_ptr + PTR_W'(pop);
            level  <= level + LVL_W'(push0) + LVL_W'(push1) - LVL_W'(pop);
        end
    end

    always_ff @(posedge CLK) begin
        if (push0) begin
            mem[wr_ptr] <= wdata0;
        end
        if (push1) begin
            mem[wr1_ptr] <= wdata1;
        end
    end

endmodule

// File: rtl/lmi_watch_trace.sv
// rtl/lmi_watch_trace.sv - watchpoint matcher feeding a trace FIFO with lost-record counting
module lmi_watch_trace
    import lmi_watch_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int NUM_WP = 4,
    parameter int DEPTH  = 8,
    parameter int LOST_W = 8,
    localparam int WP_IDX_W = (NUM_WP > 1) ? $clog2(NUM_WP) : 1,
    localparam int LVL_W    = $clog2(DEPTH) + 1
) (
    input  logic                CLK,
    input  logic                RESET_D1_R_N,
    input  logic                FREEZE,
    input  logic                LW_ISAMPLE_S,
    input  logic [ADDR_W-1:0]   LW_IADDR_S_R,
    input  logic                LW_DSAMPLE_W,
    input  logic                LW_DWRITE_W_R,
    input  logic [3:0]          LW_DBYEN_W_R,
    input  logic [ADDR_W-1:0]   LW_DADDR_W_R,
    input  logic [DATA_W-1:0]   LW_DATA_W_R,
    input  logic                WP_WE,
    input  logic [WP_IDX_W-1:0] WP_IDX,
    input  logic [ADDR_W-1:0]   WP_BASE,
    input  logic [ADDR_W-1:0]   WP_MASK,
    input  logic [3:0]          WP_CTRL,
    input  logic                TR_READY,
    output logic                TR_VALID,
    output logic [1:0]          TR_TYPE,
    output logic [WP_IDX_W-1:0] TR_WP,
    output logic [3:0]          TR_BYEN,
    output logic [ADDR_W-1:0]   TR_ADDR,
    output logic [DATA_W-1:0]   TR_DATA,
    output logic [LVL_W-1:0]    TR_LEVEL,
    output logic [LOST_W-1:0]   LOST_CNT,
    input  logic                LOST_CLR
);

    localparam int REC_W        = rec_width(ADDR_W, DATA_W, WP_IDX_W);
    localparam int REC_ADDR_LSB = REC_DATA_LSB + DATA_W;
    localparam int REC_WP_LSB   = REC_ADDR_LSB + ADDR_W;

    logic [ADDR_W-1:0]   wp_base [NUM_WP];
    logic [ADDR_W-1:0]   wp_mask [NUM_WP];
    logic [3:0]          wp_ctrl [NUM_WP];

    logic                i_hit;
    logic                d_hit;
    logic [WP_IDX_W-1:0] i_idx;
    logic [WP_IDX_W-1:0] d_idx;
    logic                i_req;
    logic                d_req;
    tr_type_e            d_type;
    logic [REC_W-1:0]    i_rec;
    logic [REC_W-1:0]    d_rec;

    logic                push0;
    logic                push1;
    logic [REC_W-1:0]    wdata0;
    logic [REC_W-1:0]    wdata1;
    logic                pop;
    logic [REC_W-1:0]    head;
    logic [LVL_W-1:0]    level;
    logic [LVL_W:0]      free_slots;
    logic [1:0]          n_lost;
    logic [LOST_W:0]     lost_sum;
    logic [LOST_W-1:0]   lost_cnt;

    always_ff @(posedge CLK or negedge RESET_D1_R_N) begin
        if (!RESET_D1_R_N) begin
            for (int i = 0; i < NUM_WP; i++) begin
                wp_base[i] <= '0;
                wp_mask[i] <= '0;
                wp_ctrl[i] <= '0;
            end
        end else if (WP_WE && (int'(WP_IDX) < NUM_WP)) begin
            wp_base[WP_IDX] <= WP_BASE;
            wp_mask[WP_IDX] <= WP_MASK;
            wp_ctrl[WP_IDX] <= WP_CTRL;
        end
    end

    // Descending scan so the lowest matching index is the one left standing
    always_comb begin
        i_hit = 1'b0;
        i_idx = '0;
        d_hit = 1'b0;
        d_idx = '0;
        for (int i = NUM_WP - 1; i >= 0; i--) begin
            if (wp_ctrl[i][CTRL_EN] && wp_ctrl[i][CTRL_IFETCH] &&
                (((LW_IADDR_S_R ^ wp_base[i]) & wp_mask[i]) == '0)) begin
                i_hit = 1'b1;
                i_idx = WP_IDX_W'(i);
            end
            if (wp_ctrl[i][CTRL_EN] &&
                (LW_DWRITE_W_R ? wp_ctrl[i][CTRL_DWRITE] : wp_ctrl[i][CTRL_DREAD]) &&
                (((LW_DADDR_W_R ^ wp_base[i]) & wp_mask[i]) == '0)) begin
                d_hit = 1'b1;
                d_idx = WP_IDX_W'(i);
            end
        end
    end

    assign i_req  = LW_ISAMPLE_S & i_hit & ~FREEZE;
    assign d_req  = LW_DSAMPLE_W & d_hit & ~FREEZE;
    assign d_type = LW_DWRITE_W_R ? TR_DWRITE : TR_DREAD;
    assign d_rec  = {d_idx, LW_DADDR_W_R, LW_DATA_W_R, LW_DBYEN_W_R, d_type};
    assign i_rec  = {i_idx, LW_IADDR_S_R, {DATA_W{1'b0}}, 4'h0, TR_IFETCH};

    assign TR_VALID   = (level != '0);
    assign pop        = TR_VALID & TR_READY;
    assign free_slots = (LVL_W + 1)'(DEPTH) - {1'b0, level} + (LVL_W + 1)'(pop);

    // D record always takes the first slot; I only gets in behind it
    always_comb begin
        push0  = 1'b0;
        push1  = 1'b0;
        wdata0 = i_rec;
        wdata1 = i_rec;
        n_lost = 2'd0;
        if (d_req && i_req) begin
            wdata0 = d_rec;
            if (free_slots >= (LVL_W + 1)'(2)) begin
                push0 = 1'b1;
                push1 = 1'b1;
            end else if (free_slots >= (LVL_W + 1)'(1)) begin
                push0  = 1'b1;
                n_lost = 2'd1;
            end else begin
                n_lost = 2'd2;
            end
        end else if (d_req || i_req) begin
            if (d_req) begin
                wdata0 = d_rec;
            end
            if (free_slots >= (LVL_W + 1)'(1)) begin
                push0 = 1'b1;
            end else begin
                n_lost = 2'd1;
            end
        end
    end

    lmi_watch_fifo #(
        .WIDTH (REC_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .CLK          (CLK),
        .RESET_D1_R_N (RESET_D1_R_N),
        .push0        (push0),
        .wdata0       (wdata0),
        .push1        (push1),
        .wdata1       (wdata1),
        .pop          (pop),
        .rdata        (head),
        .level        (level)
    );

    assign lost_sum = {1'b0, lost_cnt} + (LOST_W + 1)'(n_lost);

    always_ff @(posedge CLK or negedge RESET_D1_R_N) begin
        if (!RESET_D1_R_N) begin
            lost_cnt <= '0;
        end else if (LOST_CLR) begin
            lost_cnt <= LOST_W'(n_lost);
        end else if (lost_sum[LOST_W]) begin
            lost_cnt <= '1;
        end else begin
            lost_cnt <= lost_sum[LOST_W-1:0];
        end
    end

    // Head fields read as zero while the queue is empty
    assign TR_TYPE  = TR_VALID ? head[REC_TYPE_LSB +: 2]          : '0;
    assign TR_BYEN  = TR_VALID ? head[REC_BYEN_LSB +: 4]          : '0;
    assign TR_DATA  = TR_VALID ? head[REC_DATA_LSB +: DATA_W]     : '0;
    assign TR_ADDR  = TR_VALID ? head[REC_ADDR_LSB +: ADDR_W]     : '0;
    assign TR_WP    = TR_VALID ? head[REC_WP_LSB   +: WP_IDX_W]   : '0;
    assign TR_LEVEL = level;
    assign LOST_CNT = lost_cnt;

endmodule

// File: tb/tb_lmi_watch_trace.sv
// tb/tb_lmi_watch_trace.sv - scoreboard bench for lmi_watch_trace
module tb_lmi_watch_trace;

    logic        CLK = 1'b0;
    logic        RESET_D1_R_N;
    logic        FREEZE;
    logic        LW_ISAMPLE_S;
    logic [31:0] LW_IADDR_S_R;
    logic        LW_DSAMPLE_W;
    logic        LW_DWRITE_W_R;
    logic [3:0]  LW_DBYEN_W_R;
    logic [31:0] LW_DADDR_W_R;
    logic [31:0] LW_DATA_W_R;
    logic        WP_WE;
    logic [1:0]  WP_IDX;
    logic [31:0] WP_BASE;
    logic [31:0] WP_MASK;
    logic [3:0]  WP_CTRL;
    logic        TR_READY;
    logic        TR_VALID;
    logic [1:0]  TR_TYPE;
    logic [1:0]  TR_WP;
    logic [3:0]  TR_BYEN;
    logic [31:0] TR_ADDR;
    logic [31:0] TR_DATA;
    logic [3:0]  TR_LEVEL;
    logic [7:0]  LOST_CNT;
    logic        LOST_CLR;

    typedef struct {
        logic [1:0]  t;
        logic [1:0]  wp;
        logic [3:0]  byen;
        logic [31:0] addr;
        logic [31:0] data;
    } rec_t;

    rec_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    lmi_watch_trace dut (
        .CLK           (CLK),
        .RESET_D1_R_N  (RESET_D1_R_N),
        .FREEZE        (FREEZE),
        .LW_ISAMPLE_S  (LW_ISAMPLE_S),
        .LW_IADDR_S_R  (LW_IADDR_S_R),
        .LW_DSAMPLE_W  (LW_DSAMPLE_W),
        .LW_DWRITE_W_R (LW_DWRITE_W_R),
        .LW_DBYEN_W_R  (LW_DBYEN_W_R),
        .LW_DADDR_W_R  (LW_DADDR_W_R),
        .LW_DATA_W_R   (LW_DATA_W_R),
        .WP_WE         (WP_WE),
        .WP_IDX        (WP_IDX),
        .WP_BASE       (WP_BASE),
        .WP_MASK       (WP_MASK),
        .WP_CTRL       (WP_CTRL),
        .TR_READY      (TR_READY),
        .TR_VALID      (TR_VALID),
        .TR_TYPE       (TR_TYPE),
        .TR_WP         (TR_WP),
        .TR_BYEN       (TR_BYEN),
        .TR_ADDR       (TR_ADDR),
        .TR_DATA       (TR_DATA),
        .TR_LEVEL      (TR_LEVEL),
        .LOST_CNT      (LOST_CNT),
        .LOST_CLR      (LOST_CLR)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [79:0] act, input logic [79:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
        LW_ISAMPLE_S = 1'b0;
        LW_DSAMPLE_W = 1'b0;
        WP_WE        = 1'b0;
        LOST_CLR     = 1'b0;
    endtask

    task automatic set_wp(input logic [1:0] idx, input logic [31:0] base,
                          input logic [31:0] mask, input logic [3:0] ctrl);
        WP_WE   = 1'b1;
        WP_IDX  = idx;
        WP_BASE = base;
        WP_MASK = mask;
        WP_CTRL = ctrl;
    endtask

    task automatic istrobe(input logic [31:0] a);
        LW_ISAMPLE_S = 1'b1;
        LW_IADDR_S_R = a;
    endtask

    task automatic dstrobe(input logic wr, input logic [3:0] b,
                           input logic [31:0] a, input logic [31:0] d);
        LW_DSAMPLE_W  = 1'b1;
        LW_DWRITE_W_R = wr;
        LW_DBYEN_W_R  = b;
        LW_DADDR_W_R  = a;
        LW_DATA_W_R   = d;
    endtask

    task automatic expect_rec(input logic [1:0] t, input logic [1:0] w, input logic [3:0] b,
                              input logic [31:0] a, input logic [31:0] d);
        rec_t r;
        r.t = t; r.wp = w; r.byen = b; r.addr = a; r.data = d;
        exp_q.push_back(r);
    endtask

    task automatic drain();
        int n = 0;
        TR_READY = 1'b1;
        while (TR_LEVEL != 4'd0 && n < 40) begin
            step();
            n++;
        end
        chk("drain_level", 80'(TR_LEVEL), 80'd0);
    endtask

    // Monitor: every accepted head record is compared against the scoreboard
    initial begin
        rec_t r;
        forever begin
            @(negedge CLK);
            if (TR_VALID === 1'b1 && TR_READY === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_record: got addr %0h type %0h, no record expected",
                             TR_ADDR, TR_TYPE);
                end else begin
                    r = exp_q.pop_front();
                    chk("record", {TR_TYPE, TR_WP, TR_BYEN, TR_ADDR, TR_DATA},
                        {r.t, r.wp, r.byen, r.addr, r.data});
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1);
    end

    initial begin
        RESET_D1_R_N = 1'b0;
        FREEZE = 1'b0; LW_ISAMPLE_S = 1'b0; LW_IADDR_S_R = '0;
        LW_DSAMPLE_W = 1'b0; LW_DWRITE_W_R = 1'b0; LW_DBYEN_W_R = '0;
        LW_DADDR_W_R = '0; LW_DATA_W_R = '0; WP_WE = 1'b0; WP_IDX = '0;
        WP_BASE = '0; WP_MASK = '0; WP_CTRL = '0; TR_READY = 1'b1; LOST_CLR = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        chk("reset_valid", 80'(TR_VALID), 80'd0);
        chk("reset_level", 80'(TR_LEVEL), 80'd0);
        chk("reset_lost",  80'(LOST_CNT), 80'd0);
        chk("reset_addr",  80'(TR_ADDR),  80'd0);
        @(negedge CLK);
        RESET_D1_R_N = 1'b1;
        step();

        // 1: ifetch watch, one-cycle latency
        set_wp(2'd0, 32'h1000, 32'hFFFF_F000, 4'b1100);
        step();
        istrobe(32'h1234);
        expect_rec(2'b00, 2'd0, 4'h0, 32'h1234, 32'h0);
        step();
        chk("latency_valid", 80'(TR_VALID), 80'd1);
        step();

        // 2: dwrite-only watch ignores loads
        set_wp(2'd1, 32'h2000, 32'hFFFF_FF00, 4'b1001);
        step();
        dstrobe(1'b0, 4'hF, 32'h2010, 32'h1111);
        step();
        chk("load_ignored", 80'(TR_VALID), 80'd0);
        dstrobe(1'b1, 4'h3, 32'h2020, 32'hDEAD_BEEF);
        expect_rec(2'b10, 2'd1, 4'h3, 32'h2020, 32'hDEAD_BEEF);
        step();
        step();

        // 3: priority and same-cycle watchpoint write
        set_wp(2'd2, 32'h1000, 32'hFFFF_F000, 4'b1100);
        step();
        istrobe(32'h1500);
        expect_rec(2'b00, 2'd0, 4'h0, 32'h1500, 32'h0);
        step();
        set_wp(2'd0, 32'h0, 32'h0, 4'b0000);
        istrobe(32'h1600);
        expect_rec(2'b00, 2'd0, 4'h0, 32'h1600, 32'h0);
        step();
        istrobe(32'h1700);
        expect_rec(2'b00, 2'd2, 4'h0, 32'h1700, 32'h0);
        step();
        step();

        // 4: overflow with consumer stalled
        TR_READY = 1'b0;
        for (int i = 0; i < 9; i++) begin
            dstrobe(1'b1, 4'hF, 32'h2000 + 32'(4 * i), 32'(i));
            if (i < 8) expect_rec(2'b10, 2'd1, 4'hF, 32'h2000 + 32'(4 * i), 32'(i));
            step();
        end
        chk("full_level", 80'(TR_LEVEL), 80'd8);
        chk("full_lost",  80'(LOST_CNT), 80'd1);
        chk("full_head",  80'(TR_ADDR),  80'h2000);
        drain();
        LOST_CLR = 1'b1;
        step();
        chk("lost_clear", 80'(LOST_CNT), 80'd0);

        // 5: dual-match arbitration near full
        TR_READY = 1'b0;
        for (int i = 0; i < 7; i++) begin
            dstrobe(1'b1, 4'hF, 32'h2080 + 32'(4 * i), 32'h100 + 32'(i));
            expect_rec(2'b10, 2'd1, 4'hF, 32'h2080 + 32'(4 * i), 32'h100 + 32'(i));
            step();
        end
        chk("lvl7", 80'(TR_LEVEL), 80'd7);
        istrobe(32'h1800);
        dstrobe(1'b1, 4'h1, 32'h2040, 32'hAA);
        expect_rec(2'b10, 2'd1, 4'h1, 32'h2040, 32'hAA);
        step();
        chk("dual_nopop_level", 80'(TR_LEVEL), 80'd8);
        chk("dual_nopop_lost",  80'(LOST_CNT), 80'd1);
        TR_READY = 1'b1;
        istrobe(32'h1804);
        dstrobe(1'b1, 4'h2, 32'h2044, 32'hBB);
        expect_rec(2'b10, 2'd1, 4'h2, 32'h2044, 32'hBB);
        step();
        chk("dual_fullpop_level", 80'(TR_LEVEL), 80'd8);
        chk("dual_fullpop_lost",  80'(LOST_CNT), 80'd2);
        step();
        step();
        chk("lvl6", 80'(TR_LEVEL), 80'd6);
        istrobe(32'h1808);
        dstrobe(1'b1, 4'h4, 32'h2048, 32'hCC);
        expect_rec(2'b10, 2'd1, 4'h4, 32'h2048, 32'hCC);
        expect_rec(2'b00, 2'd2, 4'h0, 32'h1808, 32'h0);
        step();
        chk("dual_pop_level", 80'(TR_LEVEL), 80'd7);
        chk("dual_pop_lost",  80'(LOST_CNT), 80'd2);
        drain();

        // 6: saturation, clear with losses, freeze, async reset
        TR_READY = 1'b0;
        for (int i = 0; i < 8; i++) begin
            dstrobe(1'b1, 4'hF, 32'h2000 + 32'(4 * i), 32'h300 + 32'(i));
            expect_rec(2'b10, 2'd1, 4'hF, 32'h2000 + 32'(4 * i), 32'h300 + 32'(i));
            step();
        end
        for (int i = 0; i < 253; i++) begin
            dstrobe(1'b1, 4'hF, 32'h2000, 32'h0);
            step();
        end
        chk("lost_255", 80'(LOST_CNT), 80'd255);
        dstrobe(1'b1, 4'hF, 32'h2000, 32'h0);
        step();
        chk("lost_sat", 80'(LOST_CNT), 80'd255);
        LOST_CLR = 1'b1;
        istrobe(32'h1900);
        dstrobe(1'b1, 4'hF, 32'h2004, 32'h0);
        step();
        chk("clr_with_loss", 80'(LOST_CNT), 80'd2);
        drain();
        FREEZE = 1'b1;
        TR_READY = 1'b0;
        for (int i = 0; i < 3; i++) begin
            istrobe(32'h1A00);
            dstrobe(1'b1, 4'hF, 32'h2008, 32'h0);
            step();
        end
        chk("freeze_level", 80'(TR_LEVEL), 80'd0);
        chk("freeze_lost",  80'(LOST_CNT), 80'd2);
        FREEZE = 1'b0;
        for (int i = 0; i < 5; i++) begin
            dstrobe(1'b1, 4'hF, 32'h2010, 32'h0);
            step();
        end
        chk("pre_reset_level", 80'(TR_LEVEL), 80'd5);
        #2;
        RESET_D1_R_N = 1'b0;
        #1;
        chk("async_valid", 80'(TR_VALID), 80'd0);
        chk("async_level", 80'(TR_LEVEL), 80'd0);
        chk("async_lost",  80'(LOST_CNT), 80'd0);
        @(negedge CLK);
        RESET_D1_R_N = 1'b1;
        TR_READY = 1'b1;
        step();
        istrobe(32'h1234);
        step();
        chk("wp_cleared", 80'(TR_VALID), 80'd0);
        step();
        chk("queue_empty", 80'(exp_q.size()), 80'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
